// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared CPU front-end types (sequencer op codes, default address width).
`default_nettype none

package pc_sequencer_pkg;

  localparam int DEFAULT_ADDR_W = 19;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    BRANCH = 3'd1,
    JMP    = 3'd2,
    CALL   = 3'd3,
    RET    = 3'd4,
    RETI   = 3'd5,
    HOLD   = 3'd6,
    RSVD   = 3'd7
  } pc_op_t;

  // Ops that leave the stack alone can have an interrupt folded into them.
  function automatic logic irq_allowed(input pc_op_t op);
    return (op == SEQ) || (op == BRANCH) || (op == JMP) || (op == HOLD) || (op == RSVD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: hardware LIFO of return addresses; top entry always at entry 0.
`default_nettype none

module return_stack #(
  parameter int ADDR_W      = 19,
  parameter int STACK_DEPTH = 8,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] rdata,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~push;
  assign rdata   = mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_W'(1);
    end else if (do_pop) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Shift-register storage: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[0] <= wdata;
      for (int i = 1; i < STACK_DEPTH; i++) mem[i] <= mem[i-1];
    end else if (do_pop) begin
      for (int i = 1; i < STACK_DEPTH; i++) mem[i-1] <= mem[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with next-PC mux, return stack and single-level interrupt entry.
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] INT_VEC     = ADDR_W'(19'h00010),
  localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_enable,
  input  pc_op_t            pc_op,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic              irq_req,
  input  logic              clear_err,
  output logic [ADDR_W-1:0] pc,
  output logic              irq_ack,
  output logic              int_en,
  output logic [SP_W-1:0]   sp,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] nxt;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] top;
  logic              push_req;
  logic              pop_req;
  logic              ie_set;
  logic              take_irq;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;
  logic              full;
  logic              empty;

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    nxt       = pc;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    ie_set    = 1'b0;
    set_unf   = 1'b0;
    case (pc_op)
      SEQ, RSVD: nxt = pc_inc;
      BRANCH:    nxt = branch_taken ? target_addr : pc_inc;
      JMP:       nxt = target_addr;
      HOLD:      nxt = pc;
      CALL: begin
        nxt      = target_addr;
        push_req = 1'b1;
      end
      RET, RETI: begin
        ie_set = (pc_op == RETI);
        if (empty) begin
          nxt     = pc_inc;
          set_unf = pc_enable;
        end else begin
          nxt     = top;
          pop_req = 1'b1;
        end
      end
      default:   nxt = pc_inc;
    endcase

    // Interrupt entry pushes the address the op would have loaded.
    take_irq  = pc_enable & irq_req & int_en & irq_allowed(pc_op);
    push_data = take_irq ? nxt : pc_inc;
    pc_d      = take_irq ? INT_VEC : nxt;
    if (take_irq) push_req = 1'b1;

    push    = pc_enable & push_req & ~full;
    pop     = pc_enable & pop_req;
    set_ovf = pc_enable & push_req & full;
  end

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= RESET_VEC;
      int_en          <= 1'b1;
      irq_ack         <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      irq_ack         <= take_irq;
      stack_overflow  <= set_ovf | (stack_overflow  & ~clear_err);
      stack_underflow <= set_unf | (stack_underflow & ~clear_err);
      if (pc_enable) begin
        pc <= pc_d;
        if (take_irq)    int_en <= 1'b0;
        else if (ie_set) int_en <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with a queued scoreboard checked by an independent monitor.
`default_nettype none

module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pc_enable = 1'b0;
  pc_op_t        pc_op = SEQ;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] target_addr = '0;
  logic          irq_req = 1'b0;
  logic          clear_err = 1'b0;
  logic [AW-1:0] pc;
  logic          irq_ack;
  logic          int_en;
  logic [3:0]    sp;
  logic          stack_overflow;
  logic          stack_underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string         name;
    logic [AW-1:0] pc;
    logic [3:0]    sp;
    logic          ie;
    logic          ack;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t q[$];

  pc_sequencer #(
    .ADDR_W      (19),
    .STACK_DEPTH (8),
    .RESET_VEC   (19'h0),
    .INT_VEC     (19'h00010)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_enable       (pc_enable),
    .pc_op           (pc_op),
    .branch_taken    (branch_taken),
    .target_addr     (target_addr),
    .irq_req         (irq_req),
    .clear_err       (clear_err),
    .pc              (pc),
    .irq_ack         (irq_ack),
    .int_en          (int_en),
    .sp              (sp),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  function automatic void check(input exp_t e);
    total++;
    if (pc !== e.pc || sp !== e.sp || int_en !== e.ie || irq_ack !== e.ack ||
        stack_overflow !== e.ovf || stack_underflow !== e.unf) begin
      bad++;
      $display("FAIL %s: got pc=%h sp=%0d ie=%b ack=%b ovf=%b unf=%b, want pc=%h sp=%0d ie=%b ack=%b ovf=%b unf=%b",
               e.name, pc, sp, int_en, irq_ack, stack_overflow, stack_underflow,
               e.pc, e.sp, e.ie, e.ack, e.ovf, e.unf);
    end
  endfunction

  // Monitor: state after each edge is compared against the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) check(q.pop_front());
  end

  task automatic s(input pc_op_t op, input logic tk, input logic [AW-1:0] tgt,
                   input logic irq, input logic en, input logic clr,
                   input logic [AW-1:0] e_pc, input logic [3:0] e_sp,
                   input logic e_ie, input logic e_ack, input logic e_ovf, input logic e_unf,
                   input string name);
    exp_t e;
    @(negedge clk);
    pc_op        = op;
    branch_taken = tk;
    target_addr  = tgt;
    irq_req      = irq;
    pc_enable    = en;
    clear_err    = clr;
    e.name = name; e.pc = e_pc; e.sp = e_sp; e.ie = e_ie;
    e.ack = e_ack; e.ovf = e_ovf; e.unf = e_unf;
    q.push_back(e);
  endtask

  initial begin
    exp_t r;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    s(SEQ,    0, 0,        0, 0, 0, 19'h0,     0, 1, 0, 0, 0, "reset");
    s(SEQ,    0, 0,        0, 1, 0, 19'h1,     0, 1, 0, 0, 0, "seq1");
    s(SEQ,    0, 0,        0, 1, 0, 19'h2,     0, 1, 0, 0, 0, "seq2");
    s(SEQ,    0, 0,        0, 1, 0, 19'h3,     0, 1, 0, 0, 0, "seq3");
    s(JMP,    0, 19'h7FFFF,0, 1, 0, 19'h7FFFF, 0, 1, 0, 0, 0, "jmp_max");
    s(SEQ,    0, 0,        0, 1, 0, 19'h0,     0, 1, 0, 0, 0, "wrap");
    s(BRANCH, 0, 19'h100,  0, 1, 0, 19'h1,     0, 1, 0, 0, 0, "br_not_taken");
    s(BRANCH, 1, 19'h100,  0, 1, 0, 19'h100,   0, 1, 0, 0, 0, "br_taken");
    s(BRANCH, 1, 19'h300,  0, 0, 0, 19'h100,   0, 1, 0, 0, 0, "br_disabled");
    s(HOLD,   0, 19'h300,  0, 1, 0, 19'h100,   0, 1, 0, 0, 0, "hold");

    s(JMP,    0, 19'h5,    0, 1, 0, 19'h5,     0, 1, 0, 0, 0, "jmp5");
    s(CALL,   0, 19'h200,  0, 1, 0, 19'h200,   1, 1, 0, 0, 0, "call200");
    s(CALL,   0, 19'h300,  0, 1, 0, 19'h300,   2, 1, 0, 0, 0, "call300");
    s(RET,    0, 0,        0, 1, 0, 19'h201,   1, 1, 0, 0, 0, "ret201");
    s(RET,    0, 0,        0, 1, 0, 19'h6,     0, 1, 0, 0, 0, "ret6");

    // pc=6: first CALL pushes 7, later ones push 0x401..0x407, ninth is dropped.
    for (int i = 0; i < 9; i++)
      s(CALL, 0, 19'h400 + 19'(i), 0, 1, 0, 19'h400 + 19'(i),
        (i < 8) ? 4'(i + 1) : 4'd8, 1, 0, (i == 8), 0, $sformatf("ovf_call%0d", i));
    for (int j = 0; j < 8; j++)
      s(RET, 0, 0, 0, 1, 0, (j < 7) ? 19'h407 - 19'(j) : 19'h7,
        4'(7 - j), 1, 0, 1, 0, $sformatf("drain_ret%0d", j));
    s(RET,    0, 0,        0, 1, 0, 19'h8,     0, 1, 0, 1, 1, "underflow");
    s(HOLD,   0, 0,        0, 0, 1, 19'h8,     0, 1, 0, 0, 0, "clear_err");
    s(RET,    0, 0,        0, 1, 1, 19'h9,     0, 1, 0, 0, 1, "set_wins");
    s(HOLD,   0, 0,        0, 0, 1, 19'h9,     0, 1, 0, 0, 0, "clear_again");

    s(BRANCH, 1, 19'h40,   1, 1, 0, 19'h10,    1, 0, 1, 0, 0, "irq_entry");
    s(SEQ,    0, 0,        1, 1, 0, 19'h11,    1, 0, 0, 0, 0, "irq_masked");
    s(RETI,   0, 0,        0, 1, 0, 19'h40,    0, 1, 0, 0, 0, "reti");
    s(CALL,   0, 19'h500,  1, 1, 0, 19'h500,   1, 1, 0, 0, 0, "call_defers_irq");
    s(SEQ,    0, 0,        1, 1, 0, 19'h10,    2, 0, 1, 0, 0, "deferred_irq");
    s(RETI,   0, 0,        0, 1, 0, 19'h501,   1, 1, 0, 0, 0, "reti501");
    s(RET,    0, 0,        0, 1, 0, 19'h41,    0, 1, 0, 0, 0, "ret41");
    s(CALL,   0, 19'h600,  0, 1, 0, 19'h600,   1, 1, 0, 0, 0, "call600");
    s(SEQ,    0, 0,        1, 1, 0, 19'h10,    2, 0, 1, 0, 0, "irq_before_rst");

    @(negedge clk);
    pc_enable = 1'b0;
    irq_req   = 1'b0;
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    // Asynchronous reset between edges, with irq_ack and int_en away from reset values.
    rst_n = 1'b0;
    #1;
    r.name = "async_reset"; r.pc = 19'h0; r.sp = 0; r.ie = 1; r.ack = 0; r.ovf = 0; r.unf = 0;
    check(r);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-sequencing unit for the CPU front end: holds the program counter and computes the next fetch address for sequential, branch, jump, call, return and interrupt flow. It adds a hardware return-address stack and a single-level interrupt entry/exit mechanism. It is configurable in address width, stack depth and vector addresses. It sits between the control unit, which supplies the operation and branch decision each instruction, and instruction memory, which consumes `pc`.

## Interface
- `ADDR_W`, 19, width of `pc`, `target_addr` and stack entries
- `STACK_DEPTH`, 8, return-stack entries; must be ≥2
- `RESET_VEC`, 0, `pc` value after reset
- `INT_VEC`, 19'h00010, interrupt handler entry address
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `pc_enable` in 1: advance strobe; when 0, all state holds
- `pc_op` in 3: operation, encoded in the shared package
- `branch_taken` in 1: condition result, used only by BRANCH
- `target_addr` in ADDR_W: branch, jump or call destination
- `irq_req` in 1: level interrupt request
- `clear_err` in 1: clears the sticky error flags
- `pc` out ADDR_W: current fetch address
- `irq_ack` out 1: one-cycle pulse on interrupt entry
- `int_en` out 1: interrupts enabled
- `sp` out $clog2(STACK_DEPTH+1): number of occupied stack entries
- `stack_overflow` out 1: sticky flag
- `stack_underflow` out 1: sticky flag

## Operation
Op encoding:
- SEQ=0: `pc+1`
- BRANCH=1: `branch_taken ? target_addr : pc+1`
- JMP=2: `target_addr`
- CALL=3: push `pc+1`, then `target_addr`
- RET=4: pop into `pc`
- RETI=5: pop into `pc` and set `int_en`
- HOLD=6: no change
- 7 is reserved and behaves as SEQ

Arithmetic: `pc+1` is modulo 2^ADDR_W, so all-ones wraps to 0.

Interrupt entry:
- Condition: `pc_enable & irq_req & int_en`, and `pc_op` is one of SEQ, BRANCH, JMP or HOLD.
- The address the op would have produced (`nxt`) is pushed instead of loaded.
- Then `pc ← INT_VEC`, `int_en ← 0`, and `irq_ack` pulses.
- With CALL, RET or RETI pending, entry is deferred to the next enabled cycle. The op executes normally.

Stack:
- LIFO with `sp` counting 0..STACK_DEPTH.
- A push at `sp==STACK_DEPTH` is dropped. `stack_overflow` is set and the `pc` update still occurs (CALL → target, interrupt → INT_VEC).
- A pop at `sp==0` sets `stack_underflow`, `pc ← pc+1`, and `sp` stays 0. RETI still sets `int_en`.
- The error flags are sticky until `clear_err`. When a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values: `pc=RESET_VEC`, `sp=0`, `int_en=1`, `irq_ack=0`, `stack_overflow=0`, `stack_underflow=0`. Stack contents are don't-care.
- All outputs are registered. Every effect of the op sampled at edge N is visible after edge N, giving one cycle of latency.
- `irq_ack` is high for exactly the cycle after the entry edge. `int_en` drops on that same edge.
- `clear_err` acts regardless of `pc_enable`.
- `irq_req` while `int_en=0` is ignored, not latched. The source must hold the request until it sees `irq_ack`.
- Reset asserted mid-operation forces all reset values immediately. No push or pop completes.

## Structure
- The shared CPU package holds the `pc_op_t` 3-bit enum (SEQ, BRANCH, JMP, CALL, RET, RETI, HOLD) and the default ADDR_W constant. The control unit and this block both import it.
- Sub-module `return_stack`, parameterised by `ADDR_W` and `STACK_DEPTH`:
  - Inputs: push, pop, wdata.
  - Outputs: rdata (top entry), `sp`, full, empty.
  - It does not perform a simultaneous push and pop.
- Next-PC mux, interrupt arbitration and the error flags live in the top module.

## Test plan
- Reset then 3 SEQ with `ADDR_W=19` → `pc` = 0, 1, 2, 3. Preload `pc=19'h7FFFF` via JMP, then SEQ → `pc=0`.
- BRANCH with `target_addr=0x100`: `branch_taken=0` → `pc+1`; `branch_taken=1` → `0x100`. With `pc_enable=0` → `pc` unchanged.
- Nested CALLs:
  - CALL 0x200 at `pc=5`, then CALL 0x300 → `sp=2`.
  - RET → `pc=0x201`.
  - RET → `pc=6`, `sp=0`.
- Overflow and underflow with `STACK_DEPTH=8`:
  - 9 CALLs → `stack_overflow=1`, `sp=8`, `pc=target`.
  - RET at `sp=0` → `stack_underflow=1`, `pc+1`.
  - `clear_err` → both flags 0.
- Interrupt during BRANCH taken to 0x40 → `pc=INT_VEC`, `irq_ack` pulses 1 cycle, `int_en=0`, top of stack = 0x40. RETI → `pc=0x40`, `int_en=1`.
- `irq_req` held during CALL → CALL completes, interrupt is taken next enabled cycle and pushes the CALL's next address. Assert `rst_n` low mid-sequence → all outputs return to reset values asynchronously.
